peripheral_ram_ctrl_wb: RTL and testbench
=========================================

// Module: peripheral_ram_ctrl_wb
// PURPOSE
//   Wishbone B3 slave controller that sequences peripheral_ram_generic_wb (1-cycle read latency, byte write enables).
//   Converts classic and incrementing-burst (CTI/BTE) bus cycles into RAM we/waddr/raddr/din strobes and generates ack/err.
//   Sits between the SoC interconnect and the RAM macro; the datapath is pass-through, and control, addressing and ack are owned here.
// PARAMETERS
//   DEPTH  256               RAM depth in 32-bit words; need not be a power of 2
//   AW     $clog2(DEPTH)+2   wishbone byte-address width
//   RAW    $clog2(DEPTH)     RAM word-address width
//   DW     32                data width (fixed 32; 4 byte lanes)
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      reset, asynchronous assert, active-low
//   wb_adr_i     in   AW     byte address; [1:0] ignored
//   wb_dat_i     in   DW     write data
//   wb_sel_i     in   4      byte lane select
//   wb_we_i      in   1      1=write 0=read
//   wb_cti_i     in   3      000 classic, 001 const, 010 incr burst, 111 end
//   wb_bte_i     in   2      00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   wb_cyc_i     in   1      bus cycle valid
//   wb_stb_i     in   1      strobe
//   wb_dat_o     out  DW     read data (= ram_dout)
//   wb_ack_o     out  1      transfer acknowledge
//   wb_err_o     out  1      out-of-range access
//   ram_we       out  4      RAM byte write enables
//   ram_din      out  DW     RAM write data (= wb_dat_i)
//   ram_waddr    out  RAW    RAM write word address
//   ram_raddr    out  RAW    RAM read word address
//   ram_dout     in   DW     RAM registered read data
// BEHAVIOUR
//   Definitions:
//   - valid = wb_cyc_i & wb_stb_i
//   - word = wb_adr_i[AW-1:2]
//   - oor = (word >= DEPTH)
//   Reset (rst_n=0, async): state=IDLE, ack_q=0, err_q=0, so wb_ack_o=0, wb_err_o=0 and ram_we=0.
//   The abort is immediate, including mid-burst; the RAM contents are untouched.
//   Outputs: wb_ack_o = ack_q & valid; wb_err_o = err_q & valid.
//   Neither output is ever high without the strobe.
//   FSM IDLE:
//   - valid & oor -> ERR: err_q<=1 for 1 cycle, no write, then IDLE.
//   - valid & cti==010 -> BURST, ack_q<=1.
//   - valid & other cti -> SINGLE, ack_q<=1.
//   FSM SINGLE:
//   - ack_q<=0, -> IDLE.
//   - Classic/const = 2 cycles per beat (1 wait state).
//   FSM BURST, while valid & cti==010: ack_q held 1, one beat per cycle.
//   FSM BURST, exits:
//   - valid & cti==111 -> last beat acked this cycle, ack_q<=0, -> IDLE.
//   - valid low (master wait or cyc drop) -> ack_q<=0, -> IDLE; the next beat pays 1 wait state again.
//   - next burst address oor -> ERR.
//   Read addressing:
//   - ram_raddr = (state==BURST & ack_q) ? next(word) : word.
//   - The RAM therefore presents the next beat's data when the master advances.
//   next(word), by bte:
//   - 00: word+1, wrapping at 2^RAW.
//   - 01/10/11: increment the low 2/3/4 bits only; the upper bits are held.
//   Writes: ram_waddr = word; ram_we = wb_sel_i & {4{valid & wb_we_i & ack_q}}.
//   Each write commits exactly in its ack cycle; a master holding stb across a wait state causes no double write.
//   Read data: wb_dat_o = ram_dout, valid whenever wb_ack_o=1 & ~wb_we_i.
//   Mixed we within a burst: honoured per beat.
//   Read-after-write to the same word on consecutive beats returns the old data; the RAM has no bypass (documented, not a bug).
// TESTING
//   T1 Classic single write, adr 0x10, dat 0xA5A5_1234, sel 1111:
//      ack 1 cycle after stb; ram_we=1111 for 1 cycle, waddr=4.
//      Then a classic read of 0x10 returns 0xA5A5_1234.
//   T2 Byte lanes: write sel 0010, dat 0x0000_BB00 over 0xA5A5_1234 -> read back 0xA5A5_BB34.
//   T3 Incrementing linear read burst, 8 beats from 0x20:
//      first ack 1 cycle after stb, then ack every cycle.
//      Data = words 8..15 in order; ack drops the cycle after cti=111.
//   T4 Wrap4 burst from 0x38 (word 14): beats address words 14,15,12,13; wrap8 from word 14 -> 14,15,8..13.
//   T5 Master wait state mid-burst (stb low 2 cycles at beat 3):
//      no ack while stb low; resumes with 1 wait state.
//      No duplicate/missing data; no extra ram_we pulses.
//   T6 DEPTH=200: access to word 200 -> wb_err_o 1 cycle, no ack, ram_we stays 0.
//      rst_n low mid-burst -> ack/err 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/peripheral_ram_ctrl_wb_if.sv
// ----------------------------------------------------------------------------
// peripheral_ram_ctrl_wb_if
//   Wishbone B3 bus bundle between an interconnect master and the RAM
//   controller slave.
//   Signals:
//     adr   byte address (low two bits are the byte offset)
//     wdat  write data, master to slave
//     rdat  read data, slave to master
//     sel   byte lane select
//     we    1 = write, 0 = read
//     cti   cycle type (000 classic, 001 const, 010 incr burst, 111 end)
//     bte   burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//     cyc   bus cycle valid
//     stb   strobe
//     ack   transfer acknowledge
//     err   error (out-of-range access)
//   Modports: master drives the request side, slave drives rdat/ack/err.
// ----------------------------------------------------------------------------
interface peripheral_ram_ctrl_wb_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic [3:0]    sel;
    logic          we;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          cyc;
    logic          stb;
    logic          ack;
    logic          err;

    modport master (
        output adr, wdat, sel, we, cti, bte, cyc, stb,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, wdat, sel, we, cti, bte, cyc, stb,
        output rdat, ack, err
    );
endinterface

// File: rtl/peripheral_ram_ctrl_wb.sv
// ----------------------------------------------------------------------------
// peripheral_ram_ctrl_wb
//   Wishbone B3 slave that sequences a RAM macro with one cycle of registered
//   read latency and byte write enables. Classic and constant-address cycles
//   take two clocks per beat; incrementing bursts (linear or wrap4/8/16) run
//   at one beat per clock after the first. Out-of-range words answer with err.
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     wb         Wishbone slave bundle (peripheral_ram_ctrl_wb_if.slave)
//     ram_we     RAM byte write enables
//     ram_din    RAM write data (pass-through of wb.wdat)
//     ram_waddr  RAM write word address
//     ram_raddr  RAM read word address (look-ahead during bursts)
//     ram_dout   RAM registered read data (pass-through to wb.rdat)
// ----------------------------------------------------------------------------
module peripheral_ram_ctrl_wb #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH) + 2,
    parameter int RAW   = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    peripheral_ram_ctrl_wb_if.slave        wb,
    output logic [3:0]                     ram_we,
    output logic [31:0]                    ram_din,
    output logic [RAW-1:0]                 ram_waddr,
    output logic [RAW-1:0]                 ram_raddr,
    input  logic [31:0]                    ram_dout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SINGLE = 2'd1;
    localparam logic [1:0] BURST  = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    localparam logic [2:0] CTI_INCR = 3'b010;

    localparam logic [RAW:0] DEPTH_W = DEPTH[RAW:0];

    logic [1:0]     state;
    logic           ack_q;
    logic           err_q;
    logic           valid;
    logic [RAW-1:0] word;
    logic [RAW-1:0] wrap_mask;
    logic [RAW-1:0] next_word;
    logic           oor;
    logic           next_oor;
    logic           unused_adr_lsb;

    // Decode the current request: a live strobe, the word it points at, and
    // whether that word (or the word a burst will move to next) lies beyond
    // the end of the RAM. DEPTH need not be a power of two, so both checks
    // are real comparisons rather than a spare address bit.
    assign valid          = wb.cyc & wb.stb;
    assign word           = wb.adr[RAW+1:2];
    assign unused_adr_lsb = ^wb.adr[1:0];
    assign oor            = ({1'b0, word} >= DEPTH_W);
    assign next_oor       = ({1'b0, next_word} >= DEPTH_W);

    // Work out the address of the following burst beat. Bits covered by the
    // mask count up and roll over; bits outside it are held, which gives
    // wrap4/8/16. A linear burst uses a full mask and wraps at 2^RAW.
    always_comb begin
        wrap_mask = '1;
        case (wb.bte)
            2'b01:   wrap_mask = {{(RAW-2){1'b0}}, 2'b11};
            2'b10:   wrap_mask = {{(RAW-3){1'b0}}, 3'b111};
            2'b11:   wrap_mask = {{(RAW-4){1'b0}}, 4'b1111};
            default: wrap_mask = '1;
        endcase
        next_word = (word & ~wrap_mask) | ((word + RAW'(1)) & wrap_mask);
    end

    // Drive the RAM and the bus responses. While a burst is streaming the
    // read port looks one beat ahead so the registered RAM output already
    // holds the next beat's data when the master advances its address.
    // Writes only fire in an acknowledged cycle, so a master that holds its
    // strobe through the wait state never writes twice.
    assign ram_raddr = (state == BURST && ack_q) ? next_word : word;
    assign ram_waddr = word;
    assign ram_din   = wb.wdat;
    assign ram_we    = wb.sel & {4{valid & wb.we & ack_q}};
    assign wb.rdat   = ram_dout;
    assign wb.ack    = ack_q & valid;
    assign wb.err    = err_q & valid;

    // Transfer sequencer. A fresh request always costs one wait state while
    // the RAM read is issued; after that a burst keeps ack high every cycle
    // until the master ends it, pauses its strobe, or walks off the end of
    // the RAM. Any pause drops back to IDLE so the next beat re-issues its
    // read and pays the wait state again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (oor) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else if (wb.cti == CTI_INCR) begin
                            state <= BURST;
                            ack_q <= 1'b1;
                        end else begin
                            state <= SINGLE;
                            ack_q <= 1'b1;
                        end
                    end
                end
                SINGLE: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                end
                BURST: begin
                    if (valid && wb.cti == CTI_INCR) begin
                        if (next_oor) begin
                            state <= ERR;
                            ack_q <= 1'b0;
                            err_q <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_ram_ctrl_wb.sv
// ----------------------------------------------------------------------------
// tb_peripheral_ram_ctrl_wb
//   Self-checking bench for peripheral_ram_ctrl_wb built with DEPTH=200 so
//   that out-of-range words exist. A behavioural RAM with one cycle of read
//   latency sits behind the controller; a separate reference memory tracks
//   what every word should hold. Read expectations are queued as each beat
//   is driven and compared when the controller acknowledges the beat.
// ----------------------------------------------------------------------------
module tb_peripheral_ram_ctrl_wb;

    localparam int DEPTH = 200;
    localparam int RAW   = $clog2(DEPTH);
    localparam int AW    = RAW + 2;

    logic           clk;
    logic           rst_n;
    logic [3:0]     ram_we;
    logic [31:0]    ram_din;
    logic [RAW-1:0] ram_waddr;
    logic [RAW-1:0] ram_raddr;
    logic [31:0]    ram_dout;

    logic [31:0]    ram_mem [0:255];
    logic [31:0]    ref_mem [0:255];
    logic [31:0]    exp_q [$];
    logic [31:0]    exp_val;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;

    peripheral_ram_ctrl_wb_if #(.AW(AW), .DW(32)) wb ();

    peripheral_ram_ctrl_wb #(.DEPTH(DEPTH), .AW(AW), .RAW(RAW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM macro: byte-lane writes and a registered read port.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram_mem[ram_raddr];
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Bench-side burst address sequence, written as divide/modulo on spans.
    function automatic int bench_next(input int w, input logic [1:0] bte);
        int span;
        case (bte)
            2'b01:   span = 4;
            2'b10:   span = 8;
            2'b11:   span = 16;
            default: span = 0;
        endcase
        if (span == 0) return (w + 1) % 256;
        return (w / span) * span + ((w + 1) % span);
    endfunction

    // Watch the bus mid-cycle: score acknowledged reads against the queue,
    // count write pulses, and make sure ack/err never show without a strobe.
    always @(negedge clk) begin
        checkOutput("strobe_gate", 64'((wb.ack | wb.err) & ~(wb.cyc & wb.stb)), 64'(0));
        if (ram_we != 4'b0000) we_cnt++;
        if (wb.ack && !wb.we) begin
            if (exp_q.size() == 0) begin
                checkOutput("rd_unexpected_ack", 64'(1), 64'(0));
            end else begin
                exp_val = exp_q.pop_front();
                checkOutput("rd_data", 64'(wb.rdat), 64'(exp_val));
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_idle();
        wb.cyc  = 1'b0;
        wb.stb  = 1'b0;
        wb.we   = 1'b0;
        wb.cti  = 3'b000;
        wb.bte  = 2'b00;
        wb.sel  = 4'h0;
        wb.adr  = '0;
        wb.wdat = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One classic or constant-address transfer; expects exactly one wait state.
    task automatic applyStimulus(input int word, input logic is_write,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input logic [2:0] cti);
        int waits;
        int we_start;
        we_start = we_cnt;
        if (!is_write) exp_q.push_back(ref_mem[word]);
        wb.adr  = AW'(word * 4);
        wb.wdat = dat;
        wb.sel  = sel;
        wb.we   = is_write;
        wb.cti  = cti;
        wb.bte  = 2'b00;
        wb.cyc  = 1'b1;
        wb.stb  = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (!wb.ack && waits < 10) begin
            checkOutput("single_no_we_before_ack", 64'(ram_we), 64'(0));
            waits++;
            @(negedge clk);
        end
        checkOutput("single_ack_latency", 64'(waits), 64'(1));
        if (is_write) begin
            checkOutput("single_we", 64'(ram_we), 64'(sel));
            checkOutput("single_waddr", 64'(ram_waddr), 64'(word));
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
        end
        next_cycle();
        drive_idle();
        next_cycle();
        next_cycle();
        checkOutput("single_we_pulses", 64'(we_cnt - we_start), is_write ? 64'(1) : 64'(0));
    endtask

    // Incrementing burst with optional master stall before beat stall_beat.
    task automatic applyBurst(input int start_word, input int n_beats,
                              input logic [1:0] bte, input logic is_write,
                              input int stall_beat, input int stall_len);
        int w;
        int waits;
        int we_start;
        logic [31:0] d;
        w = start_word;
        we_start = we_cnt;
        for (int beat = 0; beat < n_beats; beat++) begin
            if (beat == stall_beat) begin
                wb.stb = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    checkOutput("stall_no_ack", 64'(wb.ack), 64'(0));
                    checkOutput("stall_no_we", 64'(ram_we), 64'(0));
                    next_cycle();
                end
            end
            d = 32'hD000_0000 | (32'(w) << 8) | 32'(beat);
            wb.adr  = AW'(w * 4);
            wb.we   = is_write;
            wb.wdat = d;
            wb.sel  = 4'hF;
            wb.cti  = (beat == n_beats - 1) ? 3'b111 : 3'b010;
            wb.bte  = bte;
            wb.cyc  = 1'b1;
            wb.stb  = 1'b1;
            if (!is_write) exp_q.push_back(ref_mem[w]);
            waits = 0;
            @(negedge clk);
            while (!wb.ack && waits < 10) begin
                waits++;
                @(negedge clk);
            end
            checkOutput("burst_wait", 64'(waits),
                        (beat == 0 || beat == stall_beat) ? 64'(1) : 64'(0));
            if (is_write) begin
                checkOutput("burst_waddr", 64'(ram_waddr), 64'(w));
                ref_mem[w] = d;
            end
            w = bench_next(w, bte);
            next_cycle();
        end
        @(negedge clk);
        checkOutput("burst_end_ack_drop", 64'(wb.ack), 64'(0));
        next_cycle();
        drive_idle();
        next_cycle();
        next_cycle();
        checkOutput("burst_we_pulses", 64'(we_cnt - we_start),
                    is_write ? 64'(n_beats) : 64'(0));
    endtask

    // Out-of-range access: err for one cycle, no ack, no write.
    task automatic applyOor(input int word, input logic is_write);
        int we_start;
        we_start = we_cnt;
        wb.adr  = AW'(word * 4);
        wb.wdat = 32'hDEAD_BEEF;
        wb.sel  = 4'hF;
        wb.we   = is_write;
        wb.cti  = 3'b000;
        wb.cyc  = 1'b1;
        wb.stb  = 1'b1;
        @(negedge clk);
        checkOutput("oor_err_first_cycle", 64'(wb.err), 64'(0));
        @(negedge clk);
        checkOutput("oor_err", 64'(wb.err), 64'(1));
        checkOutput("oor_no_ack", 64'(wb.ack), 64'(0));
        checkOutput("oor_no_we", 64'(ram_we), 64'(0));
        @(negedge clk);
        checkOutput("oor_err_one_cycle", 64'(wb.err), 64'(0));
        next_cycle();
        drive_idle();
        next_cycle();
        next_cycle();
        checkOutput("oor_we_pulses", 64'(we_cnt - we_start), 64'(0));
    endtask

    // Main sequence.
    initial begin
        rst_n = 1'b0;
        drive_idle();
        wb.cyc = 1'b1;
        wb.stb = 1'b1;
        wb.we  = 1'b1;
        wb.sel = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ack", 64'(wb.ack), 64'(0));
        checkOutput("reset_err", 64'(wb.err), 64'(0));
        checkOutput("reset_we", 64'(ram_we), 64'(0));
        next_cycle();
        drive_idle();
        #2 rst_n = 1'b1;
        next_cycle();
        next_cycle();

        $display("[TB] classic write/read and byte lanes");
        applyStimulus(4, 1'b1, 32'hA5A5_1234, 4'b1111, 3'b000);
        applyStimulus(4, 1'b0, 32'h0, 4'b1111, 3'b000);
        applyStimulus(4, 1'b1, 32'h0000_BB00, 4'b0010, 3'b000);
        applyStimulus(4, 1'b0, 32'h0, 4'b1111, 3'b001);

        $display("[TB] linear and wrapping bursts");
        applyBurst(8, 8, 2'b00, 1'b1, -1, 0);
        applyBurst(8, 8, 2'b00, 1'b0, -1, 0);
        applyBurst(14, 4, 2'b01, 1'b0, -1, 0);
        applyBurst(14, 8, 2'b10, 1'b0, -1, 0);

        $display("[TB] master stalls mid-burst");
        applyBurst(8, 8, 2'b00, 1'b0, 3, 2);
        applyBurst(16, 8, 2'b00, 1'b1, 3, 2);
        applyBurst(16, 8, 2'b00, 1'b0, -1, 0);

        $display("[TB] out-of-range accesses");
        applyOor(200, 1'b0);
        applyOor(200, 1'b1);
        applyOor(255, 1'b1);

        $display("[TB] reset during a burst");
        exp_q.push_back(ref_mem[8]);
        wb.adr = AW'(8 * 4);
        wb.we  = 1'b0;
        wb.sel = 4'hF;
        wb.cti = 3'b010;
        wb.bte = 2'b00;
        wb.cyc = 1'b1;
        wb.stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_burst_beat0_ack", 64'(wb.ack), 64'(1));
        next_cycle();
        exp_q.push_back(ref_mem[9]);
        wb.adr = AW'(9 * 4);
        @(negedge clk);
        checkOutput("mid_burst_beat1_ack", 64'(wb.ack), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_abort_ack", 64'(wb.ack), 64'(0));
        checkOutput("rst_abort_err", 64'(wb.err), 64'(0));
        checkOutput("rst_abort_we", 64'(ram_we), 64'(0));
        next_cycle();
        wb.adr = AW'(10 * 4);
        @(negedge clk);
        checkOutput("rst_hold_ack", 64'(wb.ack), 64'(0));
        next_cycle();
        drive_idle();
        #2 rst_n = 1'b1;
        next_cycle();
        next_cycle();
        applyStimulus(4, 1'b0, 32'h0, 4'b1111, 3'b000);
        applyStimulus(20, 1'b0, 32'h0, 4'b1111, 3'b000);

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
